tug_referee: RTL
================

Name: tug_referee

Overview:
- Match controller for the 9-light tug-of-war field.
- Conditions both players' raw keys into single-cycle move pulses and arbitrates same-cycle presses.
- Detects round wins from the field's light vector, keeps per-player scores, and sequences the field reset between rounds.
- Sits between the KEY inputs and the nine light FSMs. Drives their p1in/p2in and reset inputs, and feeds the score displays.

Parameters:
- N_LIGHTS, 9, width of the light vector; index N_LIGHTS-1 is the player-1 goal end, index 0 is the player-2 goal end.
- SCORE_W, 3, score counter width.
- SCORE_MAX, 7, score that ends the match; must be ≤ 2^SCORE_W-1.
- HOLD_CYCLES, 4, cycles the win is displayed before the field resets (board build overrides with a large value).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; clock clk.
- key_p1  in  1  raw player-1 button, active-high, asynchronous to clk.
- key_p2  in  1  raw player-2 button, active-high, asynchronous to clk.
- lights  in  N_LIGHTS  current light states from the field.
- p1_move  out  1  one-cycle move pulse to the field (player 1).
- p2_move  out  1  one-cycle move pulse to the field (player 2).
- field_reset  out  1  reset to all light FSMs.
- p1_score  out  SCORE_W  player-1 rounds won.
- p2_score  out  SCORE_W  player-2 rounds won.
- winner  out  2  00 none, 01 player 1, 10 player 2; 11 never driven.
- game_over  out  1  match finished.

Behaviour:
- Reset values: p1_move=0, p2_move=0, p1_score=0, p2_score=0, winner=00, game_over=0, state=PLAY.
- field_reset = reset OR (state==RESET_FIELD), combinational, so the field resets in the same cycle as the controller.
- Conditioning, per key:
  - Three-flop chain s1→s2→s3; edge = s2 & ~s3.
  - A key first sampled high at edge k gives edge true between edges k+1 and k+2.
  - Only one edge per press; a held key never repeats.
  - Reset clears the chain to 0. A key already held through reset therefore produces an edge after reset.
- Arbitration:
  - Accepted p1 press = e1 & ~e2; accepted p2 press = e2 & ~e1.
  - Both edges in the same cycle count as a tie: both are dropped and nothing is driven.
- All outputs are registered. p*_move is high for exactly one cycle, the cycle after the accepted edge (edge k+2 to k+3).
- FSM states: PLAY, WIN_HOLD, RESET_FIELD, GAME_OVER.
- PLAY, accepted p1 press:
  - If lights[N_LIGHTS-1]=1: no pulse; p1_score += 1 (saturating at SCORE_MAX); winner←01; hold counter←0; go to WIN_HOLD.
  - Otherwise: p1_move=1 next cycle.
- PLAY, accepted p2 press: symmetric, using lights[0], winner←10 and p2_move.
- WIN_HOLD:
  - Counter increments each cycle; all edges are discarded.
  - When the counter reaches HOLD_CYCLES-1: if the winning player's score (as updated on win entry) == SCORE_MAX, go to GAME_OVER; else go to RESET_FIELD.
- RESET_FIELD:
  - Lasts exactly one cycle with field_reset=1 and winner←00, then returns to PLAY.
  - Edges arriving in this cycle are discarded.
- GAME_OVER:
  - game_over=1; winner and scores are held.
  - No pulses are issued; only reset leaves this state.
- Light vector: only the two end bits are examined; no other validity checking.
- Reset mid-hold or mid-match:
  - Scores, winner and counter clear; state returns to PLAY; the field resets.
  - A pulse in flight is cancelled.

Decomposition:
- Shared package tug_pkg holds:
  - enum of FSM states (PLAY, WIN_HOLD, RESET_FIELD, GAME_OVER);
  - winner codes WIN_NONE=00, WIN_P1=01, WIN_P2=10;
  - default N_LIGHTS.
- One sub-module, key_edge: 3-flop synchroniser plus edge detector, instantiated once per player.

Test Plan (bench overrides: HOLD_CYCLES=4, SCORE_MAX=2):
- Reset, then lights=000010000; key_p1 high for 5 cycles starting at edge k -> single p1_move pulse between edges k+2 and k+3; p2_move stays 0.
- key_p1 and key_p2 rise on the same edge -> no move pulses in the following 6 cycles; scores unchanged.
- lights=100000000, then a p1 press -> no p1_move pulse; p1_score=1 and winner=01 on the next cycle, held for 4 cycles; field_reset high for one cycle; winner=00; back to PLAY.
- p2 wins twice (lights=000000001) -> after the second hold, game_over=1, p2_score=2, winner=10; later presses produce no pulses.
- Press during WIN_HOLD, and a press held from WIN_HOLD into PLAY -> no pulses, and no delayed pulse after return to PLAY.
- reset asserted during the 2nd hold cycle -> next cycle: scores=0, winner=00, field_reset=1 for that reset cycle, state PLAY.

Source files
------------

// File: rtl/tug_pkg.sv
// rtl/tug_pkg.sv - shared states, winner codes and field width for the tug-of-war referee
package tug_pkg;

    localparam int N_LIGHTS_DEFAULT = 9;

    typedef enum logic [1:0] {
        PLAY        = 2'd0,
        WIN_HOLD    = 2'd1,
        RESET_FIELD = 2'd2,
        GAME_OVER   = 2'd3
    } state_e;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

endpackage

// File: rtl/key_edge.sv
// rtl/key_edge.sv - three-flop synchroniser for a raw key with a one-cycle rising-edge output
module key_edge (
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic rise
);

    logic [2:0] sync_q;
    logic [2:0] sync_d;

    always_comb begin
        sync_d = {sync_q[1:0], key};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= sync_d;
        end
    end

    // sync_q[0] is the metastability stage and is never looked at directly
    assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/tug_referee.sv
// rtl/tug_referee.sv - match controller: key arbitration, round wins, scores and field reset sequencing
module tug_referee #(
    parameter int N_LIGHTS    = tug_pkg::N_LIGHTS_DEFAULT,
    parameter int SCORE_W     = 3,
    parameter int SCORE_MAX   = 7,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                key_p1,
    input  logic                key_p2,
    input  logic [N_LIGHTS-1:0] lights,
    output logic                p1_move,
    output logic                p2_move,
    output logic                field_reset,
    output logic [SCORE_W-1:0]  p1_score,
    output logic [SCORE_W-1:0]  p2_score,
    output logic [1:0]          winner,
    output logic                game_over
);

    import tug_pkg::*;

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [SCORE_W-1:0] SCORE_TOP = SCORE_W'(SCORE_MAX);
    localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);

    logic e1;
    logic e2;
    logic acc_p1;
    logic acc_p2;
    logic unused_lights;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCORE_W-1:0] p1_score_q, p1_score_d;
    logic [SCORE_W-1:0] p2_score_q, p2_score_d;
    logic [1:0]         winner_q, winner_d;
    logic               p1_move_q, p1_move_d;
    logic               p2_move_q, p2_move_d;
    logic [SCORE_W-1:0] win_score;

    key_edge u_edge_p1 (
        .clk   (clk),
        .reset (reset),
        .key   (key_p1),
        .rise  (e1)
    );

    key_edge u_edge_p2 (
        .clk   (clk),
        .reset (reset),
        .key   (key_p2),
        .rise  (e2)
    );

    // Simultaneous edges cancel each other out
    assign acc_p1 = e1 & ~e2;
    assign acc_p2 = e2 & ~e1;

    // Only the goal ends matter; interior lights are ignored
    assign unused_lights = ^lights[N_LIGHTS-2:1];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        p1_score_d = p1_score_q;
        p2_score_d = p2_score_q;
        winner_d   = winner_q;
        p1_move_d  = 1'b0;
        p2_move_d  = 1'b0;
        win_score  = (winner_q == WIN_P1) ? p1_score_q : p2_score_q;

        unique case (state_q)
            PLAY: begin
                if (acc_p1) begin
                    if (lights[N_LIGHTS-1]) begin
                        p1_score_d = (p1_score_q == SCORE_TOP) ? p1_score_q : p1_score_q + SCORE_ONE;
                        winner_d   = WIN_P1;
                        cnt_d      = '0;
                        state_d    = WIN_HOLD;
                    end else begin
                        p1_move_d = 1'b1;
                    end
                end else if (acc_p2) begin
                    if (lights[0]) begin
                        p2_score_d = (p2_score_q == SCORE_TOP) ? p2_score_q : p2_score_q + SCORE_ONE;
                        winner_d   = WIN_P2;
                        cnt_d      = '0;
                        state_d    = WIN_HOLD;
                    end else begin
                        p2_move_d = 1'b1;
                    end
                end
            end
            WIN_HOLD: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == HOLD_LAST) begin
                    if (win_score == SCORE_TOP) begin
                        state_d = GAME_OVER;
                    end else begin
                        // Winner clears as the field reset begins
                        winner_d = WIN_NONE;
                        state_d  = RESET_FIELD;
                    end
                end
            end
            RESET_FIELD: begin
                state_d = PLAY;
            end
            GAME_OVER: begin
                state_d = GAME_OVER;
            end
            default: begin
                state_d = PLAY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= PLAY;
            cnt_q      <= '0;
            p1_score_q <= '0;
            p2_score_q <= '0;
            winner_q   <= WIN_NONE;
            p1_move_q  <= 1'b0;
            p2_move_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            p1_score_q <= p1_score_d;
            p2_score_q <= p2_score_d;
            winner_q   <= winner_d;
            p1_move_q  <= p1_move_d;
            p2_move_q  <= p2_move_d;
        end
    end

    assign p1_move     = p1_move_q;
    assign p2_move     = p2_move_q;
    assign p1_score    = p1_score_q;
    assign p2_score    = p2_score_q;
    assign winner      = winner_q;
    assign game_over   = (state_q == GAME_OVER);
    assign field_reset = reset | (state_q == RESET_FIELD);

endmodule
